// File: rtl/nbiot_sc_mapper_if.sv
// Stream bundle for the NB-IoT subcarrier mapper: symbol input stream and bin output stream.
// A transfer happens on a rising edge where valid and ready are both high. The source holds its
// payload stable while valid is high and ready is low, and never makes valid depend on ready.
interface nbiot_sc_mapper_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_im;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic [5:0]    out_idx;
  logic          out_last;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last
  );
endinterface

// File: rtl/nbiot_sc_mapper.sv
// NB-IoT uplink subcarrier mapper: decodes ISC, buffers N modulated symbols, then emits all NSC
// bins of one SC-FDMA symbol in index order, zero-filling the unallocated tones.
module nbiot_sc_mapper #(
  parameter int DW  = 32,
  parameter int NSC = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         isc,
  input  logic               isc_load,
  output logic               cfg_err,
  output logic [1:0]         dbg_state,
  nbiot_sc_mapper_if.slave   bus
);

  localparam int         AW       = (NSC > 1) ? $clog2(NSC) : 1;
  localparam logic [5:0] LAST_BIN = 6'(NSC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [5:0]     k0, k0_nxt;
  logic [5:0]     n_tones, n_nxt;
  logic [5:0]     cnt, cnt_nxt;
  logic [5:0]     bin, bin_nxt;
  logic           cfg_err_nxt;
  logic           wr_en;
  logic           dec_ok;
  logic [5:0]     dec_k0;
  logic [5:0]     dec_n;
  logic [5:0]     rd_off;
  logic           in_alloc;
  logic [2*DW-1:0] rd_data;
  logic [2*DW-1:0] mem [NSC];

  assign dbg_state = state;

  // ISC to (start tone, tone count); 3.75 kHz spacing only supports single-tone.
  always_comb begin
    dec_ok = 1'b0;
    dec_k0 = '0;
    dec_n  = '0;
    if (NSC == 48) begin
      if (isc < 6'd48) begin
        dec_ok = 1'b1;
        dec_k0 = isc;
        dec_n  = 6'd1;
      end
    end else if (isc <= 6'd11) begin
      dec_ok = 1'b1;
      dec_k0 = isc;
      dec_n  = 6'd1;
    end else begin
      case (isc)
        6'd12: begin dec_ok = 1'b1; dec_k0 = 6'd0; dec_n = 6'd3;  end
        6'd13: begin dec_ok = 1'b1; dec_k0 = 6'd3; dec_n = 6'd3;  end
        6'd14: begin dec_ok = 1'b1; dec_k0 = 6'd6; dec_n = 6'd3;  end
        6'd15: begin dec_ok = 1'b1; dec_k0 = 6'd9; dec_n = 6'd3;  end
        6'd16: begin dec_ok = 1'b1; dec_k0 = 6'd0; dec_n = 6'd6;  end
        6'd17: begin dec_ok = 1'b1; dec_k0 = 6'd6; dec_n = 6'd6;  end
        6'd18: begin dec_ok = 1'b1; dec_k0 = 6'd0; dec_n = 6'd12; end
        default: dec_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    k0_nxt      = k0;
    n_nxt       = n_tones;
    cnt_nxt     = cnt;
    bin_nxt     = bin;
    cfg_err_nxt = 1'b0;
    wr_en       = 1'b0;
    case (state)
      IDLE: begin
        if (isc_load) begin
          if (dec_ok) begin
            k0_nxt    = dec_k0;
            n_nxt     = dec_n;
            cnt_nxt   = '0;
            state_nxt = FILL;
          end else begin
            cfg_err_nxt = 1'b1;
          end
        end
      end
      FILL: begin
        if (bus.in_valid && bus.in_ready) begin
          wr_en   = 1'b1;
          cnt_nxt = cnt + 6'd1;
          if (cnt_nxt == n_tones) begin
            state_nxt = EMIT;
            bin_nxt   = '0;
          end
        end
      end
      EMIT: begin
        if (bus.out_valid && bus.out_ready) begin
          if (bin == LAST_BIN) begin
            state_nxt = IDLE;
            bin_nxt   = '0;
          end else begin
            bin_nxt = bin + 6'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output bin is looked up for the next cycle so every output field is a flop. The bypass
  // covers N=1 at k0=0, where bin 0 is needed on the same edge that writes the only sample.
  always_comb begin
    rd_off   = bin_nxt - k0;
    in_alloc = (state_nxt == EMIT) && (bin_nxt >= k0) && (bin_nxt < (k0 + n_tones));
    rd_data  = '0;
    if (in_alloc) begin
      if (wr_en && (rd_off == cnt)) rd_data = {bus.in_re, bus.in_im};
      else                          rd_data = mem[rd_off[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      k0            <= '0;
      n_tones       <= '0;
      cnt           <= '0;
      bin           <= '0;
      cfg_err       <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_re    <= '0;
      bus.out_im    <= '0;
      bus.out_idx   <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      state         <= state_nxt;
      k0            <= k0_nxt;
      n_tones       <= n_nxt;
      cnt           <= cnt_nxt;
      bin           <= bin_nxt;
      cfg_err       <= cfg_err_nxt;
      bus.in_ready  <= (state_nxt == FILL);
      bus.out_valid <= (state_nxt == EMIT);
      bus.out_re    <= rd_data[2*DW-1:DW];
      bus.out_im    <= rd_data[DW-1:0];
      bus.out_idx   <= bin_nxt;
      bus.out_last  <= (state_nxt == EMIT) && (bin_nxt == LAST_BIN);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt[AW-1:0]] <= {bus.in_re, bus.in_im};
  end

endmodule

// File: tb/tb_nbiot_sc_mapper.sv
// Bench for nbiot_sc_mapper: NSC=12 instance driven by a vector table, hand sequences and random
// symbols against a tone-placement model; an NSC=48 instance covers single-tone 3.75 kHz mapping.
module tb_nbiot_sc_mapper;
  localparam int DW  = 32;
  localparam int NSC = 12;
  localparam int W   = 2*DW + 7;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] isc;
  logic       isc_load;
  logic       cfg_err;
  logic [1:0] dbg_state;
  logic [5:0] isc48;
  logic       load48;
  logic       err48;
  logic [1:0] dbg48;

  always #5 clk = ~clk;

  nbiot_sc_mapper_if #(.DW(DW)) sb ();
  nbiot_sc_mapper_if #(.DW(DW)) sb48 ();

  nbiot_sc_mapper #(.DW(DW), .NSC(12)) dut (
    .clk(clk), .reset(rst), .isc(isc), .isc_load(isc_load),
    .cfg_err(cfg_err), .dbg_state(dbg_state), .bus(sb.slave)
  );

  nbiot_sc_mapper #(.DW(DW), .NSC(48)) dut48 (
    .clk(clk), .reset(rst), .isc(isc48), .isc_load(load48),
    .cfg_err(err48), .dbg_state(dbg48), .bus(sb48.slave)
  );

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  logic [W-1:0] exp_q[$];
  logic [DW-1:0] d_re[48];
  logic [DW-1:0] d_im[48];

  typedef struct {
    logic [5:0] isc;
    bit         ok;
    int         k0;
    int         n;
    int         base;
    int         mode;
    bit         poke;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_bin(input bit last, input logic [5:0] idx,
                                            input logic [DW-1:0] re, input logic [DW-1:0] im);
    return {last, idx, re, im};
  endfunction

  // reference model: tone allocation from the ISC rules
  function automatic bit ref_decode(input int nsc, input int isc_v, output int k0, output int n);
    k0 = 0;
    n  = 0;
    if (nsc == 48) begin
      if (isc_v < 48) begin k0 = isc_v; n = 1; return 1'b1; end
      return 1'b0;
    end
    if (isc_v <= 11)      begin k0 = isc_v;            n = 1;  end
    else if (isc_v <= 15) begin k0 = 3 * (isc_v - 12); n = 3;  end
    else if (isc_v <= 17) begin k0 = 6 * (isc_v - 16); n = 6;  end
    else if (isc_v == 18) begin k0 = 0;                n = 12; end
    else return 1'b0;
    return 1'b1;
  endfunction

  task automatic build_exp(input int k0, input int n);
    logic [DW-1:0] re, im;
    for (int i = 0; i < NSC; i++) begin
      re = '0;
      im = '0;
      if (i >= k0 && i < k0 + n) begin
        re = d_re[i-k0];
        im = d_im[i-k0];
      end
      exp_q.push_back(pack_bin(i == NSC-1, 6'(i), re, im));
    end
  endtask

  task automatic fill_data(input int n, input int base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      d_re[i] = rnd ? DW'($urandom) : DW'(base + i);
      d_im[i] = rnd ? DW'($urandom) : DW'(-(base + i));
    end
  endtask

  // scoreboard: every output handshake pops one expected bin; stalled bins must hold
  logic [W-1:0] held;
  logic [W-1:0] cur;
  logic [W-1:0] e;
  bit           stall_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      cur = pack_bin(sb.out_last, sb.out_idx, sb.out_re, sb.out_im);
      if (stall_prev) begin
        check("stall_valid_held", W'(sb.out_valid), W'(1));
        check("stall_fields_held", cur, held);
      end
      if (sb.out_valid && sb.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bin_unexpected got %0h expected none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL bin got %0h expected %0h", cur, e);
          end
        end
        hs_count++;
      end
      stall_prev = sb.out_valid && !sb.out_ready;
      held = cur;
    end
  end

  // driver tasks; all run from the phase 1 time unit after a rising edge
  task automatic load_isc(input logic [5:0] v, input bit ok);
    isc = v;
    isc_load = 1'b1;
    @(posedge clk); #1;
    isc_load = 1'b0;
    isc = 6'($urandom);
    check("cfg_err_pulse", W'(cfg_err), W'(!ok));
    check("in_ready_after_load", W'(sb.in_ready), W'(ok));
    @(posedge clk); #1;
    check("cfg_err_clear", W'(cfg_err), W'(0));
    check("in_ready_hold", W'(sb.in_ready), W'(ok));
  endtask

  task automatic send_sym(input int count, input bit complete);
    int  acc = 0;
    int  guard = 0;
    bit  take;
    while (acc < count && guard < 200) begin
      sb.in_valid = ($urandom_range(0, 3) != 0);
      sb.in_re = d_re[acc];
      sb.in_im = d_im[acc];
      take = sb.in_valid && sb.in_ready;
      @(posedge clk); #1;
      guard++;
      if (take) acc++;
    end
    sb.in_valid = 1'b0;
    if (acc < count) check("fill_timeout", W'(acc), W'(count));
    if (complete) begin
      check("in_ready_after_fill", W'(sb.in_ready), W'(0));
      check("first_out_valid", W'(sb.out_valid), W'(1));
      check("first_out_idx", W'(sb.out_idx), W'(0));
    end
  endtask

  task automatic drain(input int mode, input bit poke);
    int guard = 0;
    int stall = 0;
    int start = hs_count;
    bit r;
    while (exp_q.size() != 0 && guard < 400) begin
      r = 1'b1;
      if (mode == 1) r = 1'($urandom_range(0, 1));
      if (mode == 2 && sb.out_valid && sb.out_idx == 6'd1 && stall < 5) begin
        r = 1'b0;
        stall++;
      end
      sb.out_ready = r;
      if (poke && sb.out_valid && sb.out_last && r) begin
        isc = 6'd5;
        isc_load = 1'b1;
      end
      @(posedge clk); #1;
      isc_load = 1'b0;
      guard++;
    end
    sb.out_ready = 1'b1;
    if (exp_q.size() != 0) begin
      check("drain_timeout", W'(exp_q.size()), W'(0));
      exp_q.delete();
    end
    check("handshake_count", W'(hs_count - start), W'(NSC));
    check("idle_out_valid", W'(sb.out_valid), W'(0));
    check("idle_in_ready", W'(sb.in_ready), W'(0));
    if (mode == 2) check("stall_cycles", W'(stall), W'(5));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0, n, isc_v;
    bit ok;
    logic [W-1:0] exp_b;
    logic [DW-1:0] re, im;

    tbl[0]  = '{6'd14, 1'b1, 6, 3,  1,   0, 1'b0};
    tbl[1]  = '{6'd18, 1'b1, 0, 12, 100, 0, 1'b0};
    tbl[2]  = '{6'd5,  1'b1, 5, 1,  7,   0, 1'b0};
    tbl[3]  = '{6'd19, 1'b0, 0, 0,  0,   0, 1'b0};
    tbl[4]  = '{6'd12, 1'b1, 0, 3,  20,  2, 1'b0};
    tbl[5]  = '{6'd15, 1'b1, 9, 3,  30,  1, 1'b0};
    tbl[6]  = '{6'd63, 1'b0, 0, 0,  0,   0, 1'b0};
    tbl[7]  = '{6'd0,  1'b1, 0, 1,  40,  0, 1'b1};
    tbl[8]  = '{6'd11, 1'b1, 11, 1, 50,  1, 1'b0};
    tbl[9]  = '{6'd13, 1'b1, 3, 3,  60,  0, 1'b1};
    tbl[10] = '{6'd17, 1'b1, 6, 6,  70,  1, 1'b0};

    rst = 1'b1;
    isc = '0; isc_load = 1'b0; isc48 = '0; load48 = 1'b0;
    sb.in_valid = 1'b0; sb.in_re = '0; sb.in_im = '0; sb.out_ready = 1'b1;
    sb48.in_valid = 1'b0; sb48.in_re = '0; sb48.in_im = '0; sb48.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", W'(sb.in_ready), W'(0));
    check("rst_out_valid", W'(sb.out_valid), W'(0));
    check("rst_out_data", W'({sb.out_re, sb.out_im}), W'(0));
    check("rst_out_idx", W'(sb.out_idx), W'(0));
    check("rst_out_last", W'(sb.out_last), W'(0));
    check("rst_cfg_err", W'(cfg_err), W'(0));
    check("rst48_in_ready", W'(sb48.in_ready), W'(0));

    // input without an ISC load must be refused
    sb.in_valid = 1'b1;
    sb.in_re = 32'd9;
    repeat (3) begin
      @(posedge clk); #1;
      check("noload_in_ready", W'(sb.in_ready), W'(0));
      check("noload_out_valid", W'(sb.out_valid), W'(0));
    end
    sb.in_valid = 1'b0;

    // table vectors; poke entries also try a load on the final handshake, then reload at once
    for (int t = 0; t < 11; t++) begin
      load_isc(tbl[t].isc, tbl[t].ok);
      if (tbl[t].ok) begin
        fill_data(tbl[t].n, tbl[t].base, 1'b0);
        build_exp(tbl[t].k0, tbl[t].n);
        send_sym(tbl[t].n, 1'b1);
        drain(tbl[t].mode, tbl[t].poke);
      end
    end

    // reset during FILL discards the partial symbol
    load_isc(6'd16, 1'b1);
    fill_data(6, 500, 1'b0);
    send_sym(3, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midfill_rst_in_ready", W'(sb.in_ready), W'(0));
    repeat (3) begin
      @(posedge clk); #1;
      check("midfill_rst_out_valid", W'(sb.out_valid), W'(0));
    end
    fill_data(6, 200, 1'b0);
    load_isc(6'd17, 1'b1);
    build_exp(6, 6);
    send_sym(6, 1'b1);
    drain(0, 1'b0);

    // random symbols against the model
    for (int r = 0; r < 25; r++) begin
      isc_v = $urandom_range(0, 24);
      ok = ref_decode(NSC, isc_v, k0, n);
      load_isc(6'(isc_v), ok);
      if (ok) begin
        fill_data(n, 0, 1'b1);
        build_exp(k0, n);
        send_sym(n, 1'b1);
        drain($urandom_range(0, 1), 1'b0);
      end
    end

    // NSC=48 instance: one invalid ISC, then single-tone symbols
    for (int s = 0; s < 3; s++) begin
      isc_v = (s == 0) ? 50 : (s == 1) ? 47 : $urandom_range(0, 46);
      ok = ref_decode(48, isc_v, k0, n);
      isc48 = 6'(isc_v);
      load48 = 1'b1;
      @(posedge clk); #1;
      load48 = 1'b0;
      check("n48_cfg_err", W'(err48), W'(!ok));
      check("n48_in_ready", W'(sb48.in_ready), W'(ok));
      if (ok) begin
        re = DW'($urandom);
        im = DW'($urandom);
        sb48.in_valid = 1'b1; sb48.in_re = re; sb48.in_im = im;
        @(posedge clk); #1;
        sb48.in_valid = 1'b0;
        for (int i = 0; i < 48; i++) begin
          exp_b = pack_bin(i == 47, 6'(i), (i == k0) ? re : '0, (i == k0) ? im : '0);
          check("n48_bin", pack_bin(sb48.out_last, sb48.out_idx, sb48.out_re, sb48.out_im), exp_b);
          check("n48_valid", W'(sb48.out_valid), W'(1));
          @(posedge clk); #1;
        end
        check("n48_idle", W'(sb48.out_valid), W'(0));
      end else begin
        @(posedge clk); #1;
        check("n48_cfg_err_clear", W'(err48), W'(0));
        check("n48_stay_idle", W'(sb48.in_ready), W'(0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
